// File: rtl/ddc_arb_pkg.sv
// Shared types and constants for the DDC output arbiter: FSM states and
// channel-tag encoding carried alongside each sample word.
package ddc_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SLOT = 1'b1
  } arb_state_e;

  localparam int CHIDX_W = 4;

  localparam logic [CHIDX_W-1:0] CHIDX_INVALID = 4'd0;
  localparam logic [CHIDX_W-1:0] CHIDX_I       = 4'd1;
  localparam logic [CHIDX_W-1:0] CHIDX_Q       = 4'd2;

endpackage

// File: rtl/ddc_rr_pick.sv
// Combinational round-robin picker: first set bit of i_req at or above
// i_ptr, wrapping modulo NUM_REQ.
module ddc_rr_pick #(
  parameter  int NUM_REQ = 4,
  localparam int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IDX_W-1:0]   i_ptr,
  output logic               o_any,
  output logic [IDX_W-1:0]   o_win
);

  localparam logic [IDX_W:0] NREQ_L = (IDX_W+1)'(NUM_REQ);

  logic [NUM_REQ-1:0] w_rot;
  logic [IDX_W:0]     w_off;
  logic [IDX_W:0]     w_sum;

  // Rotate so the pointer position lands at bit 0; the first set bit of
  // the rotated vector is the offset of the winner from the pointer.
  assign w_rot = NUM_REQ'({i_req, i_req} >> i_ptr);
  assign o_any = |i_req;

  always_comb begin
    w_off = '0;
    for (int k = NUM_REQ-1; k >= 0; k--) begin
      if (w_rot[k]) w_off = (IDX_W+1)'(k);
    end
    w_sum = {1'b0, i_ptr} + w_off;
    o_win = (w_sum >= NREQ_L) ? IDX_W'(w_sum - NREQ_L) : IDX_W'(w_sum);
  end

endmodule

// File: rtl/ddc_out_arbiter.sv
// Shares one serial DDC output bus among NUM_REQ requesters, one slot of
// SLOT_CLK_NUM clocks per grant. DDC_ARB_PRIO0_EN gives requester 0 strict priority.
module ddc_out_arbiter
  import ddc_arb_pkg::*;
#(
  parameter  int NUM_REQ      = 4,
  parameter  int DATA_WIDTH   = 24,
  parameter  int SLOT_CLK_NUM = 8,
  localparam int IDX_W        = $clog2(NUM_REQ)
) (
  input  logic                          CLK,
  input  logic                          nRST,
  input  logic                          Arb_En,
  input  logic [NUM_REQ-1:0]            Req_Valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] Req_Data,
  input  logic [NUM_REQ*CHIDX_W-1:0]    Req_ChIdx,
  output logic [NUM_REQ-1:0]            Req_Ack,
  output logic signed [DATA_WIDTH-1:0]  Data_Out,
  output logic                          Data_Out_Valid,
  output logic [CHIDX_W-1:0]            Data_Out_ChIdx,
  output logic [IDX_W-1:0]              Data_Out_ReqIdx,
  output logic                          Busy
);

  localparam int                 CNT_W    = 5;
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(SLOT_CLK_NUM-1);
  localparam logic [IDX_W-1:0]   IDX_LAST = IDX_W'(NUM_REQ-1);
  localparam logic [NUM_REQ-1:0] ONE_HOT0 = NUM_REQ'(1);

  logic [NUM_REQ-1:0][DATA_WIDTH-1:0] w_data;
  logic [NUM_REQ-1:0][CHIDX_W-1:0]    w_tag;

  arb_state_e          r_state, w_nstate;
  logic [CNT_W-1:0]    r_cnt, w_ncnt;
  logic [IDX_W-1:0]    r_ptr;
  logic                w_grant;

  logic [NUM_REQ-1:0]    w_rr_req;
  logic                  w_rr_any;
  logic [IDX_W-1:0]      w_rr_win;
  logic                  w_any;
  logic [IDX_W-1:0]      w_win;
  logic                  w_ptr_upd;
  logic [IDX_W-1:0]      w_ptr_nxt;

  logic [NUM_REQ-1:0]    r_ack;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_vld;
  logic [CHIDX_W-1:0]    r_tag;
  logic [IDX_W-1:0]      r_idx;

  // Packed-array view matches the flat bus layout word-for-word.
  assign w_data = Req_Data;
  assign w_tag  = Req_ChIdx;

`ifdef DDC_ARB_PRIO0_EN
  // Requester 0 bypasses rotation and never moves the pointer.
  assign w_rr_req  = {Req_Valid[NUM_REQ-1:1], 1'b0};
  assign w_any     = Req_Valid[0] | w_rr_any;
  assign w_win     = Req_Valid[0] ? '0 : w_rr_win;
  assign w_ptr_upd = ~Req_Valid[0];
`else
  assign w_rr_req  = Req_Valid;
  assign w_any     = w_rr_any;
  assign w_win     = w_rr_win;
  assign w_ptr_upd = 1'b1;
`endif

  ddc_rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .i_req (w_rr_req),
    .i_ptr (r_ptr),
    .o_any (w_rr_any),
    .o_win (w_rr_win)
  );

  assign w_ptr_nxt = (w_win == IDX_LAST) ? '0 : w_win + IDX_W'(1);

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_nstate;
      r_cnt   <= w_ncnt;
    end
  end

  always_comb begin
    w_nstate = r_state;
    w_ncnt   = r_cnt;
    w_grant  = 1'b0;
    case (r_state)
      IDLE: begin
        if (Arb_En && w_any) begin
          w_grant  = 1'b1;
          w_nstate = SLOT;
          w_ncnt   = '0;
        end
      end
      SLOT: begin
        if (r_cnt == CNT_LAST) begin
          w_ncnt = '0;
          if (Arb_En && w_any) w_grant  = 1'b1;
          else                 w_nstate = IDLE;
        end else begin
          w_ncnt = r_cnt + CNT_W'(1);
        end
      end
      default: begin
        w_nstate = IDLE;
        w_ncnt   = '0;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_ptr  <= '0;
      r_ack  <= '0;
      r_vld  <= 1'b0;
      r_data <= '0;
      r_tag  <= '0;
      r_idx  <= '0;
    end else begin
      r_ack <= '0;
      r_vld <= 1'b0;
      if (w_grant) begin
        r_ack  <= ONE_HOT0 << w_win;
        r_vld  <= 1'b1;
        r_data <= w_data[w_win];
        r_tag  <= w_tag[w_win];
        r_idx  <= w_win;
        if (w_ptr_upd) r_ptr <= w_ptr_nxt;
      end
    end
  end

  assign Req_Ack         = r_ack;
  assign Data_Out        = $signed(r_data);
  assign Data_Out_Valid  = r_vld;
  assign Data_Out_ChIdx  = r_tag;
  assign Data_Out_ReqIdx = r_idx;
  assign Busy            = (r_state == SLOT);

endmodule

// File: doc/ddc_out_arbiter.md
# ddc_out_arbiter

Round-robin arbiter that shares one serial DDC output bus between NUM_REQ channel muxes. Each requester holds one 24-bit I or Q word plus its channel index; the arbiter grants one requester per output slot of SLOT_CLK_NUM clocks. It emits a one-cycle valid pulse tagged with the requester index and the passed-through channel index. It sits downstream of the per-DDC parallel-to-serial muxes and upstream of the PCIe record packer.

## Interface
- NUM_REQ, 4: number of requesters, 2..16.
- DATA_WIDTH, 24: sample word width.
- SLOT_CLK_NUM, 8: clocks per output slot, 2..31.
- IDX_W, $clog2(NUM_REQ): requester index width, derived and not overridden.

Ports:
- CLK  in  1  single clock; all logic on posedge.
- nRST  in  1  asynchronous active-low reset.
- Arb_En  in  1  high permits new grants; low blocks new grants but lets the current slot finish.
- Req_Valid  in  NUM_REQ  per-requester level request; held until the matching Req_Ack.
- Req_Data  in  NUM_REQ*DATA_WIDTH  packed words; requester r occupies bits [r*DATA_WIDTH +: DATA_WIDTH].
- Req_ChIdx  in  NUM_REQ*4  packed 4-bit channel tags (1 = I, 2 = Q, 0 = invalid).
- Req_Ack  out  NUM_REQ  one-cycle one-hot pulse; the data was captured on this edge.
- Data_Out  out  DATA_WIDTH  granted word (signed), held for the whole slot.
- Data_Out_Valid  out  1  one-cycle pulse at slot start.
- Data_Out_ChIdx  out  4  granted channel tag, held.
- Data_Out_ReqIdx  out  IDX_W  granted requester index, held.
- Busy  out  1  high while a slot is in progress.

## Operation
- Reset values: Req_Ack=0, Data_Out=0, Data_Out_Valid=0, Data_Out_ChIdx=0, Data_Out_ReqIdx=0, Busy=0, state=IDLE, slot counter=0, round-robin pointer=0.
- States:
  - IDLE: if Arb_En and any Req_Valid, grant on the next edge and go to SLOT; otherwise stay in IDLE.
  - SLOT: the counter runs 0..SLOT_CLK_NUM-1.
    - At count SLOT_CLK_NUM-1 with Arb_En and any Req_Valid, grant again on that edge (back-to-back) and reload the counter to 0.
    - At count SLOT_CLK_NUM-1 with no grant condition, go to IDLE.
- Grant edge:
  - Capture Data_Out, Data_Out_ChIdx and Data_Out_ReqIdx from the winner.
  - Pulse Req_Ack[winner] and Data_Out_Valid for one cycle; Busy=1.
- Round-robin selection: search from the pointer upward, wrapping modulo NUM_REQ; the first valid requester wins. After a grant to requester g, the pointer becomes (g+1) mod NUM_REQ.
- Arbitration uses Req_Valid only on grant-decision cycles. A requester that drops Req_Valid before being acked is simply not granted; this is not an error.
- Arb_En falling mid-slot: the slot completes and the FSM returns to IDLE. Arb_En rising in IDLE: the grant follows on the next edge.
- Outputs hold their last granted values in IDLE; only Busy falls.
- Reset mid-slot: immediate return to reset values. A requester whose ack was not pulsed keeps its word.

## Timing
- Request-to-grant latency from IDLE: one clock; Req_Valid seen high at edge N gives Req_Ack and Data_Out_Valid high after edge N+1.
- Under continuous requests, Data_Out_Valid pulses exactly every SLOT_CLK_NUM clocks.
- Busy rises with the grant edge and falls on the edge after count SLOT_CLK_NUM-1 when there is no back-to-back grant.
- Req_Ack and Data_Out_Valid are always coincident and never high two cycles in a row (SLOT_CLK_NUM >= 2).

## Configuration
- DDC_ARB_PRIO0_EN:
  - Defined: requester 0 has strict priority; it wins whenever it is valid on a decision cycle. Grants to requester 0 leave the round-robin pointer unchanged; the other requesters rotate among themselves.
  - Undefined: pure round-robin over all NUM_REQ requesters.

## Structure
- Package ddc_arb_pkg holds:
  - the state encoding (IDLE, SLOT);
  - the CHIDX_INVALID/CHIDX_I/CHIDX_Q constants (0/1/2);
  - the 4-bit channel-tag width constant.
- Sub-module ddc_rr_pick is a combinational round-robin priority picker. Inputs are the request vector and the pointer; outputs are any-valid and the winner index. The strict-priority override lives in the parent.

## Test plan
- Reset then a single request: Req_Valid=4'b0100, Req_Data[2]=24'h123456, ChIdx=1 → one clock later Req_Ack=4'b0100, Data_Out=24'h123456, ChIdx=1, ReqIdx=2, Valid pulse; Busy high for 8 clocks.
- All four requesters held valid: grants go 0,1,2,3,0, with Valid pulses exactly 8 clocks apart and no IDLE cycle between them.
- Arb_En dropped 3 clocks into a slot: the slot completes, Busy falls, no grant follows. Arb_En raised again: the next requester in rotation is granted one clock later.
- Wrap-around: pointer=3, requests {0,3} valid → 3 is granted, then 0.
- nRST asserted mid-slot: all outputs are 0 immediately; after release the first grant goes to the lowest valid index (pointer=0).
- With DDC_ARB_PRIO0_EN defined and requesters 0 and 2 valid continuously: 0 wins every slot. With the macro undefined: grants alternate 0,2,0,2.
